// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and defaults for the register file arbiter
package regfile_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DEPTH  = 8;

  localparam logic REQ_DEC = 1'b0;
  localparam logic REQ_WB  = 1'b1;

  typedef enum logic {
    INIT,
    SERVE
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with pointer update
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       rr_ptr,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       next_ptr
);

  always_comb begin
    grant    = 2'b00;
    next_ptr = rr_ptr;
    if (accept) begin
      if (valid == 2'b11) grant = rr_ptr ? 2'b10 : 2'b01;
      else                grant = valid;
    end
    // Priority passes to the requester that did not just transfer.
    if (grant[0])      next_ptr = 1'b1;
    else if (grant[1]) next_ptr = 1'b0;
  end

endmodule

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - shares the single-port register file between decode and writeback
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_in,
  input  logic [DATA_W-1:0] rf_out,
  output logic              init_busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic [1:0] grant;
  logic       next_ptr;
  logic       serve_en;

  assign serve_en = rst && (state_q == SERVE);

  rr_arbiter2 u_arb (
    .valid    ({req1_valid, req0_valid}),
    .rr_ptr   (rr_ptr_q),
    .accept   (serve_en),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    rr_ptr_d   = next_ptr;
    rd_pend_d  = 1'b0;
    rd_owner_d = rd_owner_q;
    rf_wr_en   = 1'b0;
    rf_addr    = rf_addr_q;
    rf_in      = '0;
    init_busy  = 1'b1;
    req0_ready = grant[0];
    req1_ready = grant[1];

    // Read data is the live register file output in the response cycle, then held.
    req0_rvalid = rst && rd_pend_q && (rd_owner_q == REQ_DEC);
    req1_rvalid = rst && rd_pend_q && (rd_owner_q == REQ_WB);
    rdata0_d    = req0_rvalid ? rf_out : rdata0_q;
    rdata1_d    = req1_rvalid ? rf_out : rdata1_q;

    if (!rst) begin
      state_d    = INIT;
      init_ptr_d = '0;
      rr_ptr_d   = REQ_DEC;
      rd_owner_d = REQ_DEC;
      rf_addr    = '0;
      rdata0_d   = '0;
      rdata1_d   = '0;
    end else if (state_q == INIT) begin
      rf_wr_en   = 1'b1;
      rf_addr    = init_ptr_q;
      init_ptr_d = init_ptr_q + 1'b1;
      if (init_ptr_q == LAST_ADDR) begin
        state_d    = SERVE;
        init_ptr_d = '0;
      end
    end else begin
      init_busy = 1'b0;
      if (grant[1]) begin
        rf_addr  = req1_addr;
        rf_wr_en = req1_we;
        rf_in    = req1_wdata;
      end else if (grant[0]) begin
        rf_addr  = req0_addr;
        rf_wr_en = req0_we;
        rf_in    = req0_wdata;
      end
      if (grant != 2'b00) begin
        rd_pend_d  = ~rf_wr_en;
        rd_owner_d = grant[1];
      end
    end

    rf_addr_d  = rf_addr;
    req0_rdata = rdata0_d;
    req1_rdata = rdata1_d;
  end

  always_ff @(posedge clk) begin
    state_q    <= state_d;
    init_ptr_q <= init_ptr_d;
    rr_ptr_q   <= rr_ptr_d;
    rd_pend_q  <= rd_pend_d;
    rd_owner_q <= rd_owner_d;
    rf_addr_q  <= rf_addr_d;
    rdata0_q   <= rdata0_d;
    rdata1_q   <= rdata1_d;
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - randomized self-checking bench with a behavioural arbiter model
module tb_regfile_arbiter;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] i_valid = '0;
  logic [1:0] i_we = '0;
  logic [2:0] i_addr [2];
  logic [3:0] i_wdata [2];
  logic [1:0] o_ready;
  logic [1:0] o_rvalid;
  logic [3:0] o_rdata [2];
  logic       rf_wr_en;
  logic [2:0] rf_addr;
  logic [3:0] rf_in;
  logic [3:0] rf_out;
  logic       init_busy;
  logic [3:0] rf_mem [DEPTH];

  int n_cmp = 0;
  int n_err = 0;

  int m_mem [DEPTH];
  int init_left, init_idx, pref, last_addr;
  int last_rd [2];
  int waitc [2];
  bit pend_v;
  int pend_own, pend_data;

  always #5 clk = ~clk;

  regfile_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (i_valid[0]),
    .req0_we     (i_we[0]),
    .req0_addr   (i_addr[0]),
    .req0_wdata  (i_wdata[0]),
    .req0_ready  (o_ready[0]),
    .req0_rvalid (o_rvalid[0]),
    .req0_rdata  (o_rdata[0]),
    .req1_valid  (i_valid[1]),
    .req1_we     (i_we[1]),
    .req1_addr   (i_addr[1]),
    .req1_wdata  (i_wdata[1]),
    .req1_ready  (o_ready[1]),
    .req1_rvalid (o_rvalid[1]),
    .req1_rdata  (o_rdata[1]),
    .rf_wr_en    (rf_wr_en),
    .rf_addr     (rf_addr),
    .rf_in       (rf_in),
    .rf_out      (rf_out),
    .init_busy   (init_busy)
  );

  // Single-port register file with registered read output.
  always @(posedge clk) begin
    if (rf_wr_en) rf_mem[rf_addr] <= rf_in;
    rf_out <= rf_mem[rf_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int k, input bit v, input bit we, input int addr, input int d);
    i_valid[k] = v;
    i_we[k]    = we;
    i_addr[k]  = 3'(addr);
    i_wdata[k] = 4'(d);
  endtask

  task automatic idle();
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
  endtask

  // One clock: compare outputs against the model mid-cycle, then advance the model.
  task automatic tick();
    int g;
    bit exp_rv;
    #1;
    if (!rst) begin
      check("rst_ready", 32'(o_ready), 0);
      check("rst_rvalid", 32'(o_rvalid), 0);
      check("rst_wen", 32'(rf_wr_en), 0);
      check("rst_addr", 32'(rf_addr), 0);
      check("rst_in", 32'(rf_in), 0);
      check("rst_busy", 32'(init_busy), 1);
      check("rst_rdata0", 32'(o_rdata[0]), 0);
      check("rst_rdata1", 32'(o_rdata[1]), 0);
      pend_v    = 0;
      init_left = DEPTH;
      init_idx  = 0;
      pref      = 0;
      last_addr = 0;
      last_rd[0] = 0;
      last_rd[1] = 0;
      waitc[0]  = 0;
      waitc[1]  = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        exp_rv = pend_v && (pend_own == k);
        check("rvalid", 32'(o_rvalid[k]), 32'(exp_rv));
        if (exp_rv) last_rd[k] = pend_data;
        check("rdata", 32'(o_rdata[k]), 32'(last_rd[k]));
      end
      pend_v = 0;
      if (init_left > 0) begin
        check("init_busy", 32'(init_busy), 1);
        check("init_wen", 32'(rf_wr_en), 1);
        check("init_addr", 32'(rf_addr), 32'(init_idx));
        check("init_in", 32'(rf_in), 0);
        check("init_ready", 32'(o_ready), 0);
        m_mem[init_idx] = 0;
        last_addr = init_idx;
        init_idx++;
        init_left--;
      end else begin
        check("serve_busy", 32'(init_busy), 0);
        g = -1;
        if (i_valid[0] && i_valid[1]) g = pref;
        else if (i_valid[0])          g = 0;
        else if (i_valid[1])          g = 1;
        check("ready0", 32'(o_ready[0]), 32'(g == 0));
        check("ready1", 32'(o_ready[1]), 32'(g == 1));
        if (g < 0) begin
          check("idle_wen", 32'(rf_wr_en), 0);
          check("idle_addr", 32'(rf_addr), 32'(last_addr));
        end else begin
          check("xfer_wen", 32'(rf_wr_en), 32'(i_we[g]));
          check("xfer_addr", 32'(rf_addr), 32'(i_addr[g]));
          check("xfer_in", 32'(rf_in), 32'(i_wdata[g]));
          if (i_we[g]) m_mem[i_addr[g]] = int'(i_wdata[g]);
          else begin
            pend_v    = 1;
            pend_own  = g;
            pend_data = m_mem[i_addr[g]];
          end
          last_addr = int'(i_addr[g]);
          pref = 1 - g;
        end
        for (int k = 0; k < 2; k++) begin
          if (i_valid[k] && g != k) waitc[k]++;
          else waitc[k] = 0;
          check("starve", 32'(waitc[k] <= 1), 1);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) tick();
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      rf_mem[i] = 4'hF;
      m_mem[i]  = 15;
    end
    idle();
    @(negedge clk);
    do_reset(2);

    // Clear walk with both requesters waiting; req0 wins first.
    set_req(0, 1, 0, 0, 0);
    set_req(1, 1, 0, 5, 0);
    repeat (DEPTH + 1) tick();
    idle();
    tick();

    // Write then read-after-write of the same address.
    set_req(1, 1, 1, 3, 4'hA);
    tick();
    idle();
    set_req(0, 1, 0, 3, 0);
    tick();
    idle();
    tick();
    check("raw_rdata", 32'(o_rdata[0]), 32'h0A);

    // Preload, then both continuously reading.
    set_req(0, 1, 1, 1, 5);
    tick();
    idle();
    set_req(1, 1, 1, 2, 6);
    tick();
    set_req(0, 1, 0, 1, 0);
    set_req(1, 1, 0, 2, 0);
    repeat (8) tick();
    idle();
    tick();

    // Back-to-back reads from req1 alone.
    set_req(1, 1, 0, 3, 0);
    repeat (4) tick();
    idle();
    tick();

    // Untouched register reads as cleared.
    set_req(0, 1, 0, 7, 0);
    tick();
    idle();
    tick();
    check("clear7", 32'(o_rdata[0]), 0);

    // Reset right after a read accept drops the response and reruns the walk.
    set_req(0, 1, 1, 4, 9);
    tick();
    set_req(0, 1, 0, 4, 0);
    tick();
    idle();
    do_reset(1);
    repeat (DEPTH) tick();
    set_req(0, 1, 0, 4, 0);
    set_req(1, 1, 0, 3, 0);
    repeat (2) tick();
    idle();
    tick();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 2; k++)
        set_req(k, bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
                int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 149) == 0) do_reset(int'($urandom_range(1, 2)));
      else tick();
    end
    idle();
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
